// File: rtl/dmem_access.sv
// Load/store access unit: turns one pipeline memory operation into a word-wide
// data-memory bus transaction and returns aligned, extended load data.
module dmem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_BYTE = 2'b01;
    localparam logic [1:0] W_HALF = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         lane, lane_n;
    logic [1:0]         width, width_n;
    logic               uns, uns_n;
    logic               dm_we_n;
    logic [31:0]        dm_addr_n;
    logic [3:0]         dm_be_n;
    logic [31:0]        dm_wdata_n;
    logic               rsp_err_n;
    logic [31:0]        rsp_rdata_n;

    logic               misaligned_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        shifted_c;
    logic [31:0]        load_c;

    // Request decode: alignment check, lane enables and replicated store data
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = req_wdata;
        case (req_width)
            W_BYTE: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            W_HALF: begin
                misaligned_c = req_addr[0];
                be_c         = 4'b0011 << req_addr[1:0];
                wdata_c      = {2{req_wdata[15:0]}};
            end
            W_WORD: begin
                misaligned_c = (req_addr[1:0] != 2'b00);
                be_c         = 4'b1111;
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    // Load data: move the addressed lane down, then extend
    always_comb begin
        shifted_c = dm_rdata >> {lane, 3'b000};
        case (width)
            W_BYTE:  load_c = uns ? {24'h0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
            W_HALF:  load_c = uns ? {16'h0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lane_n      = lane;
        width_n     = width;
        uns_n       = uns;
        dm_we_n     = dm_we;
        dm_addr_n   = dm_addr;
        dm_be_n     = dm_be;
        dm_wdata_n  = dm_wdata;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = 32'h0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lane_n     = req_addr[1:0];
                    width_n    = req_width;
                    uns_n      = req_unsigned;
                    dm_we_n    = req_we;
                    dm_addr_n  = {req_addr[31:2], 2'b00};
                    dm_be_n    = be_c;
                    dm_wdata_n = wdata_c;
                    if (misaligned_c) begin
                        state_n   = RESP;
                        rsp_err_n = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (dm_gnt) begin
                    state_n = dm_we ? RESP : WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    state_n     = RESP;
                    rsp_rdata_n = load_c;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            lane      <= 2'b00;
            width     <= 2'b00;
            uns       <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'h0;
            dm_be     <= 4'b0000;
            dm_wdata  <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lane      <= lane_n;
            width     <= width_n;
            uns       <= uns_n;
            dm_we     <= dm_we_n;
            dm_addr   <= dm_addr_n;
            dm_be     <= dm_be_n;
            dm_wdata  <= dm_wdata_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    assign req_ready = (state == IDLE);
    assign dm_req    = (state == REQ);
    assign rsp_valid = (state == RESP);
    assign stall     = (state == IDLE) ? req_valid : (state != RESP);

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: a spec-level timeline/data model drives a
// per-cycle comparator, plus literal checks on captured responses.
module tb_dmem_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;

    dmem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit          chk_en = 0;
    bit          chk_bus = 0;
    logic        exp_ready, exp_stall, exp_dmreq, exp_rv, exp_err;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    logic        last_err;
    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_be;
    int          rsp_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dm_req", 32'(dm_req), 32'(exp_dmreq));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            if (chk_bus) begin
                chk("dm_we", 32'(dm_we), 32'(exp_we));
                chk("dm_addr", dm_addr, exp_addr);
                chk("dm_be", 32'(dm_be), 32'(exp_be));
                chk("dm_wdata", dm_wdata, exp_wdata);
            end
        end
        if (rsp_valid) begin
            last_err   = rsp_err;
            last_rdata = rsp_rdata;
            rsp_count++;
        end
        if (dm_req) begin
            last_addr  = dm_addr;
            last_be    = dm_be;
            last_wdata = dm_wdata;
        end
    end

    function automatic bit m_misaligned(input logic [1:0] w, input int lane);
        return (w == 2'd3) || (w == 2'd2 && (lane % 2) != 0) || (w == 2'd0 && lane != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] w, input int lane);
        int base;
        base = (w == 2'd1) ? 1 : (w == 2'd2) ? 3 : 15;
        if (w == 2'd0) return 4'(base);
        return 4'(base * (2 ** lane));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] wd);
        longint v;
        v = longint'(wd);
        if (w == 2'd1) return 32'((v % 256) * 64'h01010101);
        if (w == 2'd2) return 32'((v % 65536) * 64'h00010001);
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic u,
                                           input int lane, input logic [31:0] rd);
        longint v;
        longint span;
        v = longint'(rd) / (longint'(1) << (8 * lane));
        if (w == 2'd0) return 32'(v);
        span = (w == 2'd1) ? 256 : 65536;
        v = v % span;
        if (!u && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic set_exp(input logic rdy, input logic st, input logic dq,
                           input logic rv, input logic er, input logic [31:0] rd);
        exp_ready = rdy; exp_stall = st; exp_dmreq = dq;
        exp_rv = rv; exp_err = er; exp_rdata = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pipeline operation with scripted bus behaviour; rv_dly < 0 means no rvalid
    task automatic do_op(input logic we, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gnt_dly, input int rv_dly,
                         input logic [31:0] rd, input bit tail_idle);
        int  lane;
        bit  timed_out;
        lane = int'(a[1:0]);
        req_valid = 1'b1; req_we = we; req_width = w; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        chk_bus = 0;
        set_exp(1, 1, 0, 0, 0, 32'h0);
        step();
        if (m_misaligned(w, lane)) begin
            set_exp(0, 0, 0, 1, 1, 32'h0);
            step();
        end else begin
            exp_we = we; exp_addr = a - 32'(lane);
            exp_be = m_be(w, lane); exp_wdata = m_wdata(w, wd);
            chk_bus = 1;
            for (int i = 0; i <= gnt_dly; i++) begin
                dm_gnt = (i == gnt_dly);
                set_exp(0, 1, 1, 0, 0, 32'h0);
                step();
            end
            dm_gnt = 1'b0;
            chk_bus = 0;
            if (!we) begin
                timed_out = 1;
                for (int j = 0; j < int'(TO); j++) begin
                    dm_rvalid = (j == rv_dly);
                    dm_rdata  = (j == rv_dly) ? rd : 32'hA5A5_0000 + 32'(j);
                    set_exp(0, 1, 0, 0, 0, 32'h0);
                    step();
                    if (j == rv_dly) begin
                        timed_out = 0;
                        break;
                    end
                end
                dm_rvalid = 1'b0;
                set_exp(0, 0, 0, 1, timed_out, timed_out ? 32'h0 : m_load(w, u, lane, rd));
            end else begin
                set_exp(0, 0, 0, 1, 0, 32'h0);
            end
            step();
        end
        if (tail_idle) begin
            req_valid = 1'b0;
            set_exp(1, 0, 0, 0, 0, 32'h0);
            step();
        end
    endtask

    int rc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        step();
        step();
        // Reset state: outputs cleared, stall mirrors req_valid
        req_valid = 1'b1;
        exp_we = 0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        chk_bus = 1; chk_en = 1;
        set_exp(1, 1, 0, 0, 0, 32'h0);
        step();
        rstn = 1'b1; req_valid = 1'b0;
        set_exp(1, 0, 0, 0, 0, 32'h0);
        step();
        chk_bus = 0;

        // Store byte with immediate grant
        do_op(1, 2'b01, 0, 32'h0000_1003, 32'h0000_00AB, 0, -1, 32'h0, 1);
        chk("sb_addr", last_addr, 32'h0000_1000);
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_err", 32'(last_err), 32'h0);

        // Half loads, signed then unsigned back-to-back
        do_op(0, 2'b10, 0, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 0);
        chk("lh_data", last_rdata, 32'hFFFF_8001);
        do_op(0, 2'b10, 1, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, 1);
        chk("lhu_data", last_rdata, 32'h0000_8001);
        do_op(0, 2'b01, 1, 32'h0000_2001, 32'h0, 0, 0, 32'h8001_1234, 1);
        chk("lbu_data", last_rdata, 32'h0000_0012);
        do_op(0, 2'b01, 0, 32'h0000_2003, 32'h0, 1, 2, 32'h8011_2233, 1);
        chk("lb_data", last_rdata, 32'hFFFF_FF80);

        // Misaligned word and reserved width
        do_op(0, 2'b00, 0, 32'h0000_2001, 32'h0, 0, 0, 32'h0, 1);
        chk("lw_mis_err", 32'(last_err), 32'h1);
        do_op(1, 2'b11, 0, 32'h0000_2000, 32'h1234_5678, 0, 0, 32'h0, 1);
        chk("w11_err", 32'(last_err), 32'h1);

        // Store half with grant withheld three cycles
        do_op(1, 2'b10, 0, 32'h0000_3002, 32'h1234_BEEF, 3, -1, 32'h0, 1);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);

        // Load timeout, then a late rvalid that must be ignored
        do_op(0, 2'b00, 0, 32'h0000_0030, 32'h0, 0, -1, 32'h0, 1);
        chk("to_err", 32'(last_err), 32'h1);
        chk("to_rdata", last_rdata, 32'h0);
        rc = rsp_count;
        dm_rvalid = 1'b1; dm_rdata = 32'h1111_1111;
        set_exp(1, 0, 0, 0, 0, 32'h0);
        step();
        dm_rvalid = 1'b0;
        step();
        chk("late_rvalid_rsp", 32'(rsp_count - rc), 32'h0);

        // Reset while waiting for load data
        rc = rsp_count;
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'b00; req_addr = 32'h0000_0020;
        set_exp(1, 1, 0, 0, 0, 32'h0);
        step();
        dm_gnt = 1'b1;
        set_exp(0, 1, 1, 0, 0, 32'h0);
        step();
        dm_gnt = 1'b0; rstn = 1'b0;
        set_exp(0, 1, 0, 0, 0, 32'h0);
        step();
        rstn = 1'b1; req_valid = 1'b0;
        exp_we = 0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        chk_bus = 1;
        set_exp(1, 0, 0, 0, 0, 32'h0);
        step();
        chk_bus = 0;
        chk("rst_wait_rsp", 32'(rsp_count - rc), 32'h0);
        do_op(0, 2'b00, 0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 1);
        chk("lw_after_rst", last_rdata, 32'hDEAD_BEEF);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
# dmem_access

Load/store access unit between the decode/execute stage and the data memory. It takes one memory operation per request: direction, width (byte/half/word), signedness, ALU-computed byte address and store data. It drives a word-wide data-memory bus with byte enables and a grant/read-valid handshake. It returns aligned, sign- or zero-extended load data and a completion pulse, and holds the pipeline stalled while an access is in flight.

## Interface
- TIMEOUT, 16: maximum cycles to wait for `dm_rvalid` after a load grant before flagging an error (≥1).
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  memory operation presented (held by pipeline while `stall`=1).
- req_ready  out  1  unit idle, sampling `req_*` this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  00 word, 01 byte, 10 half, 11 reserved (error).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with `rsp_valid`: misaligned, reserved width or timeout.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- stall  out  1  pipeline hold request.
- dm_req  out  1  bus request.
- dm_we  out  1  bus write.
- dm_addr  out  32  word address: `{req_addr[31:2],2'b00}`.
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian).
- dm_wdata  out  32  lane-replicated store data.
- dm_gnt  in  1  bus accepted request this cycle.
- dm_rvalid  in  1  load data valid.
- dm_rdata  in  32  load data word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all `req_*` fields.
  - Misaligned access (half with a[0]=1, word with a[1:0]≠0) or width 11 → RESP with err=1, no bus activity.
  - Otherwise → REQ.
- REQ: `dm_req`=1. `dm_we`, `dm_addr`, `dm_be` and `dm_wdata` are stable until `dm_gnt`. No timeout in REQ.
  - `dm_gnt` on a store → RESP.
  - `dm_gnt` on a load → WAIT with the timeout counter cleared.
- WAIT: `dm_req`=0.
  - `dm_rvalid` → capture and extend the data → RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT → RESP with err=1, rdata 0.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- Byte enables (a = latched addr[1:0]):
  - byte: `4'b0001<<a`
  - half: `4'b0011<<a`
  - word: `4'b1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: unchanged
- Load extraction: shift `dm_rdata` right by 8·a, take the low 8/16/32 bits, then zero- or sign-extend to 32 per `req_unsigned`. For word loads `req_unsigned` is ignored.
- `stall` = `req_valid` in IDLE, 1 in REQ and WAIT, 0 in RESP. The pipeline advances at the end of the RESP cycle.
- `dm_rvalid` outside WAIT and `dm_gnt` outside REQ are ignored, including a late `rvalid` after a timeout.

## Timing
- Reset (`rstn`=0 at an edge, in any state):
  - state → IDLE, counter → 0.
  - `rsp_valid`, `rsp_err`, `rsp_rdata`, `dm_req`, `dm_we`, `dm_addr`, `dm_be`, `dm_wdata` → 0.
  - `req_ready`=1; `stall` follows `req_valid`.
  - Reset mid-REQ drops `dm_req` the next cycle. Reset mid-WAIT abandons the load with no response.
- Accept at cycle T. `dm_req` is high from T+1.
- Store latency with `dm_gnt` at T+1: `rsp_valid` at T+2.
- Load latency with `dm_gnt` at T+1 and `dm_rvalid` at T+2: `rsp_valid` at T+3.
- Grant delayed k cycles → response delayed k cycles.
- `dm_rvalid` is never sampled in the same cycle as `dm_gnt`.
- Misaligned or reserved access accepted at T: `rsp_valid`/`rsp_err` at T+1.
- Timeout: grant at T+1, no `rvalid` → `rsp_valid` err at T+2+TIMEOUT.
- `rsp_rdata` and `rsp_err` are registered and valid only during the `rsp_valid` cycle; they are 0 otherwise.
- Back-to-back: a new request can be accepted in the cycle after RESP (one idle cycle minimum between accesses).

## Test plan
- Store byte, addr 0x0000_1003, wdata 0x0000_00AB, gnt immediate → `dm_addr` 0x1000, `dm_be` 1000, `dm_wdata` 0xABABABAB at T+1; `rsp_valid` at T+2, err 0, rdata 0.
- Load half signed, addr 0x2002, `dm_rdata` 0x8001_1234 at T+2 → `rsp_rdata` 0xFFFF8001 at T+3. Same access with `req_unsigned`=1 → 0x0000_8001. lbu at 0x2001 → 0x0000_0012.
- lw at 0x2001 and width 11 at 0x2000 → `rsp_err`=1 at T+1; `dm_req` never asserted; `stall` high at T, low at T+1.
- Grant withheld 3 cycles → `dm_req`, `dm_addr`, `dm_be`, `dm_wdata` stable for 4 cycles, `stall`=1 throughout, response 3 cycles later than the no-wait case.
- TIMEOUT=4, load granted at T+1, no `rvalid` → `rsp_valid`, err 1, rdata 0 at T+6. A late `rvalid` at T+8 produces no response.
- `rstn` low for one cycle while in WAIT → IDLE next cycle, all outputs 0, no `rsp_valid`. A following lw at 0x10 with rdata 0xDEADBEEF → `rsp_rdata` 0xDEADBEEF.
